giraffe_frame_packer: RTL
=========================

Name: giraffe_frame_packer

Overview:
- Multi-channel successor to the single-channel ADC capture path.
- Captures N_CH ADC sample words on the rising edges of per-channel ack strobes, buffers them in a shared FIFO, and emits framed bytes to the UART transmitter over a valid/ready byte interface.
- Sits between the ADC pad interface (dout_adc/adc_ack) and the tx2M UART.
- Generalises sample width up to 16 bits, channel count, and buffer depth; adds overflow accounting and frame sequencing.

Parameters:
- N_bit, 6, ADC sample width; legal range 1..16.
- N_CH, 2, number of ADC channels; legal range 1..16.
- DEPTH, 16, FIFO entries; power of 2, at least 2.
- HEADER, 8'hA5, frame start byte.

Ports:
- clk_50M  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  capture enable; low means new ack edges are ignored.
- adc_ack  input  N_CH  per-channel sample strobe, already synchronous to clk_50M; bit i belongs to channel i.
- dout_adc  input  N_CH*N_bit  packed samples; channel i occupies [i*N_bit +: N_bit].
- tx_ready  input  1  UART can accept a byte.
- tx_valid  output  1  tx_data holds a valid byte.
- tx_data  output  8  byte to the UART.
- fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky flag: a sample was dropped.
- drop_cnt  output  16  number of dropped samples; saturates at 16'hFFFF.
- clear_ovf  input  1  one-cycle pulse that clears overflow and drop_cnt.

Behaviour:
- Reset:
  - Outputs: tx_valid=0, tx_data=0, fifo_level=0, overflow=0, drop_cnt=0.
  - Internal state: FSM in IDLE, all pending bits cleared, ack history cleared, seq=0.
  - A reset asserted mid-frame aborts the frame. FIFO contents are discarded.
- Edge detect:
  - Register ack_d <= adc_ack every cycle, regardless of enable.
  - A capture event on channel i occurs when adc_ack[i]=1, ack_d[i]=0 and enable=1.
  - A strobe held high produces exactly one event.
- Hold stage:
  - Each channel has one holding register plus a pending bit.
  - On an event, dout_adc for that channel is latched in the same cycle and pending is set.
  - If the event arrives while pending is already set, the new sample is dropped, the held sample is kept, overflow is set to 1 and drop_cnt increments.
  - If several channels drop in the same cycle, drop_cnt adds the number of drops, saturating.
- FIFO write arbitration:
  - Each cycle, the lowest-index pending channel is pushed as {ch[3:0], sample zero-extended to 16 bits} if the FIFO is not full; its pending bit is then cleared.
  - When the FIFO is full nothing is pushed and pending samples wait; they are not dropped.
  - Simultaneous push and pop leaves fifo_level unchanged. A push while full and a pop while empty are impossible by construction.
- Serializer FSM, states IDLE, HDR, TAG, DHI, DLO:
  - IDLE: if the FIFO is non-empty, pop one entry into the frame registers, drive tx_valid=1 with tx_data=HEADER, go to HDR.
  - HDR: on tx_valid&&tx_ready present TAG = {seq[3:0], ch[3:0]}, go to TAG.
  - TAG: on handshake present either the sample high byte and go to DHI (when N_bit>8), or the low byte and go to DLO.
  - DHI: on handshake present the sample low byte and go to DLO.
  - DLO: on handshake set seq <= seq+1 (wraps 15 to 0), drop tx_valid to 0, return to IDLE.
  - tx_data and tx_valid are registered and stay stable until the handshake; tx_valid never drops before the handshake.
  - At least one idle cycle separates frames.
- Latency: an event on the first cycle ack is sampled high (cycle t), with the FIFO empty and the FSM in IDLE, gives tx_valid=1 with HEADER visible from cycle t+3.
- enable low:
  - Events are not generated and not counted as drops.
  - Pending samples are still pushed, the FIFO drains, and an in-flight frame completes.
- clear_ovf: clears overflow and drop_cnt. If a drop happens in the same cycle, the result is overflow=1 and drop_cnt=number dropped that cycle.

Test Plan:
- N_CH=2, N_bit=6. After reset, pulse adc_ack[0] with ch0 sample 6'h2A, tx_ready held at 1. Expect bytes A5, 00, 2A; tx_valid rises 3 cycles after the ack edge; the next frame's TAG reads 10.
- Both acks rise in the same cycle, ch0=6'h05 and ch1=6'h3F. Expect frame ch0 (A5,00,05) then frame ch1 (A5,11,3F); overflow=0.
- tx_ready held at 0 for 1000 cycles, one ack edge every 10 cycles on ch0, DEPTH=16. Expect fifo_level to reach 16 with no drop while the hold slot is free; the next edge sets overflow=1 and drop_cnt increments once per further edge; raising tx_ready drains the FIFO in order.
- N_bit=12, sample 12'hABC on ch3. Expect bytes A5, 03, 0A, BC. A random tx_ready pattern must leave tx_data unchanged while tx_valid=1 and tx_ready=0.
- adc_ack held high for 50 cycles with enable toggling: exactly one frame results. An edge arriving with enable=0 gives no frame and no drop.
- Assert rst mid-DHI, then release. Expect tx_valid=0, fifo_level=0, seq restarted at 0; the next event produces a clean frame with TAG 0x?? carrying seq=0.

Source files
------------

// File: rtl/giraffe_frame_packer.sv
// Multi-channel ADC capture: edge-detected per-channel hold slots feed a shared FIFO,
// and a serializer emits HEADER/TAG/data byte frames over a valid/ready byte link.
module giraffe_frame_packer #(
  parameter int          N_bit  = 6,
  parameter int          N_CH   = 2,
  parameter int          DEPTH  = 16,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic                      clk_50M,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [N_CH-1:0]           adc_ack,
  input  logic [N_CH*N_bit-1:0]     dout_adc,
  input  logic                      tx_ready,
  output logic                      tx_valid,
  output logic [7:0]                tx_data,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      overflow,
  output logic [15:0]               drop_cnt,
  input  logic                      clear_ovf
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, HDR, TAG, DHI, DLO} state_t;
  state_t state_reg, state_next;

  logic [N_CH-1:0]  ack_d_reg, event_w, drop_w, pending_reg, push_sel;
  logic [N_bit-1:0] sample_w [N_CH];
  logic [N_bit-1:0] hold_reg [N_CH];
  logic [19:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             push, pop, full, empty;
  logic [3:0]       push_ch;
  logic [15:0]      push_sample;
  logic [3:0]       frame_ch_reg;
  logic [15:0]      frame_sample_reg;
  logic [3:0]       seq_reg, seq_next;
  logic             tx_valid_reg, tx_valid_next;
  logic [7:0]       tx_data_reg, tx_data_next;
  logic             ovf_reg;
  logic [15:0]      drop_cnt_reg;
  logic [4:0]       n_drop;
  logic [16:0]      cnt_sum;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_slice
      assign sample_w[gi] = dout_adc[gi*N_bit +: N_bit];
    end
  endgenerate

  assign event_w = adc_ack & ~ack_d_reg & {N_CH{enable}};
  assign drop_w  = event_w & pending_reg;

  // Lowest-index pending channel wins the FIFO write slot.
  always_comb begin
    push_sel    = '0;
    push_ch     = '0;
    push_sample = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pending_reg[i]) begin
        push_sel    = '0;
        push_sel[i] = 1'b1;
        push_ch     = 4'(i);
        push_sample = '0;
        push_sample[N_bit-1:0] = hold_reg[i];
      end
    end
  end

  assign push  = (|pending_reg) && !full;
  assign full  = (level_reg == (AW+1)'(DEPTH));
  assign empty = (level_reg == '0);

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      ack_d_reg   <= '0;
      pending_reg <= '0;
      for (int i = 0; i < N_CH; i++) hold_reg[i] <= '0;
    end else begin
      ack_d_reg <= adc_ack;
      for (int i = 0; i < N_CH; i++) begin
        if (event_w[i] && !pending_reg[i]) begin
          hold_reg[i]    <= sample_w[i];
          pending_reg[i] <= 1'b1;
        end else if (push && push_sel[i]) begin
          pending_reg[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    n_drop = '0;
    for (int i = 0; i < N_CH; i++) n_drop = n_drop + 5'(drop_w[i]);
  end

  // A clear in the same cycle as drops leaves only this cycle's drops counted.
  assign cnt_sum = (clear_ovf ? 17'd0 : {1'b0, drop_cnt_reg}) + 17'(n_drop);

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      ovf_reg      <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      ovf_reg      <= (clear_ovf ? 1'b0 : ovf_reg) | (|drop_w);
      drop_cnt_reg <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

  // Storage array with registered read straight into the frame registers.
  always_ff @(posedge clk_50M) begin
    if (push) mem[wr_ptr_reg] <= {push_ch, push_sample};
    if (pop)  {frame_ch_reg, frame_sample_reg} <= mem[rd_ptr_reg];
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + (AW+1)'(1);
        2'b01:   level_reg <= level_reg - (AW+1)'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_reg    <= IDLE;
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= '0;
      seq_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      tx_valid_reg <= tx_valid_next;
      tx_data_reg  <= tx_data_next;
      seq_reg      <= seq_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    tx_valid_next = tx_valid_reg;
    tx_data_next  = tx_data_reg;
    seq_next      = seq_reg;
    pop           = 1'b0;
    case (state_reg)
      IDLE: if (!empty) begin
        pop           = 1'b1;
        tx_valid_next = 1'b1;
        tx_data_next  = HEADER;
        state_next    = HDR;
      end
      HDR: if (tx_valid_reg && tx_ready) begin
        tx_data_next = {seq_reg, frame_ch_reg};
        state_next   = TAG;
      end
      TAG: if (tx_valid_reg && tx_ready) begin
        if (N_bit > 8) begin
          tx_data_next = frame_sample_reg[15:8];
          state_next   = DHI;
        end else begin
          tx_data_next = frame_sample_reg[7:0];
          state_next   = DLO;
        end
      end
      DHI: if (tx_valid_reg && tx_ready) begin
        tx_data_next = frame_sample_reg[7:0];
        state_next   = DLO;
      end
      DLO: if (tx_valid_reg && tx_ready) begin
        tx_valid_next = 1'b0;
        seq_next      = seq_reg + 4'd1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign tx_valid   = tx_valid_reg;
  assign tx_data    = tx_data_reg;
  assign fifo_level = level_reg;
  assign overflow   = ovf_reg;
  assign drop_cnt   = drop_cnt_reg;
endmodule
